// File: rtl/vec_dram_burst_if.sv
// vec_dram_burst_if: command/data bundle between a memory client and vec_dram_burst.
//   i_addr     start word address of a command
//   i_len      burst length (0 reads as 1, large values clamp)
//   i_rd/i_wr  read/write command request; i_wr also qualifies write beats
//   i_data_in  write data
//   o_ready    a command may be accepted this cycle
//   o_data_out registered read data
//   o_rd_valid o_data_out holds a read beat
//   o_err      one-cycle pulse after a rejected RD+WR command
interface vec_dram_burst_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 5
);
    logic [ADDR_W-1:0] i_addr;
    logic [LEN_W-1:0]  i_len;
    logic              i_rd;
    logic              i_wr;
    logic [DATA_W-1:0] i_data_in;
    logic              o_ready;
    logic [DATA_W-1:0] o_data_out;
    logic              o_rd_valid;
    logic              o_err;
    modport master (output i_addr, i_len, i_rd, i_wr, i_data_in,
                    input  o_ready, o_data_out, o_rd_valid, o_err);
    modport slave  (input  i_addr, i_len, i_rd, i_wr, i_data_in,
                    output o_ready, o_data_out, o_rd_valid, o_err);
endinterface

// File: rtl/vec_dram_burst.sv
// vec_dram_burst: burst-capable word memory with fixed read latency.
//   i_clk  sole clock
//   i_rst  synchronous active-high reset (array contents are kept)
//   bus    vec_dram_burst_if.slave command/data port
module vec_dram_burst #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 65536,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input logic               i_clk,
    input logic               i_rst,
    vec_dram_burst_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(MAX_BURST) + 1;
    localparam logic [LEN_W-1:0] MAXB = LEN_W'(MAX_BURST);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);
    // RWAIT lasts RD_LAT-1 cycles; the counter runs down to zero.
    localparam logic [3:0] LAT_INIT = 4'(RD_LAT > 1 ? RD_LAT - 2 : 0);

    typedef enum logic [1:0] {IDLE, WBURST, RWAIT, RBURST} state_t;

    logic [DATA_W-1:0] Memory [DEPTH];

    state_t            r_state, w_state_n;
    logic [IDX_W-1:0]  r_addr, w_addr_n, w_waddr, w_start;
    logic [LEN_W-1:0]  r_left, w_left_n, w_len;
    logic [3:0]        r_lat, w_lat_n;
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid, r_err;
    logic              w_idle, w_we, w_rbeat;

    assign w_idle  = r_state == IDLE;
    assign w_start = bus.i_addr[IDX_W-1:0];
    assign w_len   = bus.i_len == '0 ? ONE : (bus.i_len > MAXB ? MAXB : bus.i_len);

    always_comb begin
        w_state_n = r_state;
        w_addr_n  = r_addr;
        w_left_n  = r_left;
        w_lat_n   = r_lat;
        w_waddr   = r_addr;
        w_we      = 1'b0;
        w_rbeat   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_wr && !bus.i_rd) begin
                    // Beat 0 lands on the accept edge; only longer bursts leave IDLE.
                    w_we      = 1'b1;
                    w_waddr   = w_start;
                    w_addr_n  = w_start + IDX_W'(1);
                    w_left_n  = w_len - ONE;
                    w_state_n = w_len == ONE ? IDLE : WBURST;
                end else if (bus.i_rd && !bus.i_wr) begin
                    w_addr_n  = w_start;
                    w_left_n  = w_len;
                    w_lat_n   = LAT_INIT;
                    w_state_n = RD_LAT > 1 ? RWAIT : RBURST;
                end
            end
            WBURST: begin
                if (bus.i_wr) begin
                    w_we      = 1'b1;
                    w_addr_n  = r_addr + IDX_W'(1);
                    w_left_n  = r_left - ONE;
                    w_state_n = r_left == ONE ? IDLE : WBURST;
                end
            end
            RWAIT: begin
                w_lat_n   = r_lat - 4'd1;
                w_state_n = r_lat == 4'd0 ? RBURST : RWAIT;
            end
            RBURST: begin
                w_rbeat   = 1'b1;
                w_addr_n  = r_addr + IDX_W'(1);
                w_left_n  = r_left - ONE;
                w_state_n = r_left == ONE ? IDLE : RBURST;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_left     <= '0;
            r_lat      <= '0;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_addr     <= w_addr_n;
            r_left     <= w_left_n;
            r_lat      <= w_lat_n;
            r_data_out <= w_rbeat ? Memory[r_addr] : r_data_out;
            r_rd_valid <= w_rbeat;
            r_err      <= w_idle & bus.i_rd & bus.i_wr;
        end
    end

    // The array has no reset; a write presented together with reset is dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_we) Memory[w_waddr] <= bus.i_data_in;
    end

    assign bus.o_ready    = w_idle;
    assign bus.o_data_out = r_data_out;
    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_err      = r_err;
endmodule

// File: tb/tb_vec_dram_burst.sv
// tb_vec_dram_burst: directed and randomized checks of vec_dram_burst against a word-array model.
//   dut0 DEPTH=65536 RD_LAT=2, dut1 DEPTH=256 RD_LAT=1, dut2 DEPTH=256 RD_LAT=8; sel picks the active one.
module tb_vec_dram_burst;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel;
    logic [15:0] t_addr, t_din;
    logic [4:0]  t_len;
    logic        t_rd, t_wr;
    logic        w_ready, w_rv, w_err;
    logic [15:0] w_dout;

    vec_dram_burst_if #(.DATA_W(16), .ADDR_W(16), .LEN_W(5)) if0 ();
    vec_dram_burst_if #(.DATA_W(16), .ADDR_W(16), .LEN_W(5)) if1 ();
    vec_dram_burst_if #(.DATA_W(16), .ADDR_W(16), .LEN_W(5)) if2 ();

    vec_dram_burst #(.DEPTH(65536), .RD_LAT(2)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    vec_dram_burst #(.DEPTH(256),   .RD_LAT(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    vec_dram_burst #(.DEPTH(256),   .RD_LAT(8)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

    assign if0.i_addr = t_addr;  assign if1.i_addr = t_addr;  assign if2.i_addr = t_addr;
    assign if0.i_len  = t_len;   assign if1.i_len  = t_len;   assign if2.i_len  = t_len;
    assign if0.i_data_in = t_din; assign if1.i_data_in = t_din; assign if2.i_data_in = t_din;
    assign if0.i_rd = t_rd && sel == 0;  assign if0.i_wr = t_wr && sel == 0;
    assign if1.i_rd = t_rd && sel == 1;  assign if1.i_wr = t_wr && sel == 1;
    assign if2.i_rd = t_rd && sel == 2;  assign if2.i_wr = t_wr && sel == 2;

    assign w_ready = sel == 0 ? if0.o_ready    : sel == 1 ? if1.o_ready    : if2.o_ready;
    assign w_rv    = sel == 0 ? if0.o_rd_valid : sel == 1 ? if1.o_rd_valid : if2.o_rd_valid;
    assign w_err   = sel == 0 ? if0.o_err      : sel == 1 ? if1.o_err      : if2.o_err;
    assign w_dout  = sel == 0 ? if0.o_data_out : sel == 1 ? if1.o_data_out : if2.o_data_out;

    logic [15:0] mdl [3][65536];
    logic [15:0] wdat [16];
    int n_chk = 0;
    int n_fail = 0;

    function automatic int depth_of(input int s);
        return s == 0 ? 65536 : 256;
    endfunction

    function automatic int lat_of(input int s);
        return s == 0 ? 2 : (s == 1 ? 1 : 8);
    endfunction

    function automatic int eff_len(input logic [4:0] l);
        return l == 0 ? 1 : (l > 16 ? 16 : int'(l));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [4:0] l, input logic [15:0] stall);
        int n, d;
        n = eff_len(l);
        d = depth_of(sel);
        t_addr = a; t_len = l; t_wr = 1'b1; t_rd = 1'b0; t_din = wdat[0];
        tick;
        mdl[sel][int'(a) % d] = wdat[0];
        chk("wr_ready_beat0", 32'(w_ready), 32'(n == 1));
        for (int b = 1; b < n; b++) begin
            if (stall[b]) begin
                t_wr = 1'b0; t_rd = 1'b1; t_din = 16'($urandom);
                tick;
                chk("wr_stall_ready", 32'(w_ready), 32'(0));
                t_rd = 1'b0;
            end
            t_wr = 1'b1; t_din = wdat[b]; t_addr = 16'($urandom); t_len = 5'($urandom);
            tick;
            mdl[sel][(int'(a) + b) % d] = wdat[b];
            chk("wr_beat_ready", 32'(w_ready), 32'(b == n - 1));
        end
        t_wr = 1'b0; t_rd = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [4:0] l);
        int n, d, lat;
        logic [15:0] last;
        n = eff_len(l);
        d = depth_of(sel);
        lat = lat_of(sel);
        last = 16'h0;
        t_addr = a; t_len = l; t_rd = 1'b1; t_wr = 1'b0;
        tick;
        chk("rd_accept_ready", 32'(w_ready), 32'(0));
        chk("rd_accept_rv", 32'(w_rv), 32'(0));
        for (int k = 1; k < lat + n; k++) begin
            t_rd = 1'($urandom); t_wr = 1'($urandom);
            t_din = 16'($urandom); t_addr = 16'($urandom); t_len = 5'($urandom);
            tick;
            chk("rd_valid", 32'(w_rv), 32'(k >= lat));
            chk("rd_ready", 32'(w_ready), 32'(k == lat + n - 1));
            chk("rd_err", 32'(w_err), 32'(0));
            if (k >= lat) begin
                last = mdl[sel][(int'(a) + k - lat) % d];
                chk("rd_data", 32'(w_dout), 32'(last));
            end
        end
        t_rd = 1'b0; t_wr = 1'b0;
        tick;
        chk("rd_done_rv", 32'(w_rv), 32'(0));
        chk("rd_done_ready", 32'(w_ready), 32'(1));
        chk("rd_hold_data", 32'(w_dout), 32'(last));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        sel = 0; t_addr = '0; t_din = '0; t_len = '0; t_rd = 1'b0; t_wr = 1'b0;
        rst = 1'b1;
        tick; tick;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_ready", 32'(w_ready), 32'(1));
            chk("reset_rv", 32'(w_rv), 32'(0));
            chk("reset_err", 32'(w_err), 32'(0));
            chk("reset_dout", 32'(w_dout), 32'(0));
        end
        rst = 1'b0;
        sel = 0;
        tick;

        wdat[0] = 16'hBEEF;
        do_write(16'h0010, 5'd1, 16'h0);
        do_read(16'h0010, 5'd1);

        wdat[0] = 16'h5A5A; do_write(16'h0110, 5'd1, 16'h0);
        wdat[0] = 16'hA5A5; do_write(16'h00FF, 5'd1, 16'h0);
        for (int i = 0; i < 16; i++) wdat[i] = 16'(i);
        do_write(16'h0100, 5'd16, 16'h0220);
        do_read(16'h0100, 5'd16);
        do_read(16'h0110, 5'd1);
        do_read(16'h00FF, 5'd1);

        sel = 1;
        wdat[0] = 16'hA; wdat[1] = 16'hB; wdat[2] = 16'hC; wdat[3] = 16'hD;
        do_write(16'h00FE, 5'd4, 16'h0);
        do_read(16'h00FE, 5'd4);
        do_read(16'hFFFE, 5'd4);

        sel = 0;
        wdat[0] = 16'h1234;
        do_write(16'h0020, 5'd1, 16'h0);
        t_addr = 16'h0020; t_len = 5'd1; t_din = 16'hFFFF; t_rd = 1'b1; t_wr = 1'b1;
        tick;
        chk("err_pulse", 32'(w_err), 32'(1));
        chk("err_ready", 32'(w_ready), 32'(1));
        chk("err_rv", 32'(w_rv), 32'(0));
        t_rd = 1'b0; t_wr = 1'b0;
        tick;
        chk("err_clear", 32'(w_err), 32'(0));
        chk("err_ready_after", 32'(w_ready), 32'(1));
        do_read(16'h0020, 5'd1);

        for (int i = 0; i < 8; i++) wdat[i] = 16'h1000 + 16'(i);
        do_write(16'h0200, 5'd8, 16'h0);
        t_addr = 16'h0200; t_len = 5'd8; t_rd = 1'b0;
        for (int b = 0; b < 3; b++) begin
            t_wr = 1'b1; t_din = 16'h2000 + 16'(b);
            tick;
            mdl[0][16'h0200 + b] = 16'h2000 + 16'(b);
        end
        rst = 1'b1; t_din = 16'h2003;
        tick;
        chk("rst_mid_ready", 32'(w_ready), 32'(1));
        chk("rst_mid_rv", 32'(w_rv), 32'(0));
        chk("rst_mid_dout", 32'(w_dout), 32'(0));
        t_addr = 16'h0203; t_len = 5'd1; t_din = 16'hDEAD;
        tick;
        rst = 1'b0; t_wr = 1'b0;
        tick;
        chk("rst_release_ready", 32'(w_ready), 32'(1));
        do_read(16'h0200, 5'd8);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int i = 0; i < 16; i++) wdat[i] = 16'($urandom);
            do_write(16'h0040, 5'd16, 16'($urandom));
            do_read(16'h0040, 5'd0);
            do_read(16'h0040, 5'd31);
        end

        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int it = 0; it < 15; it++) begin
                logic [15:0] a;
                logic [4:0]  l;
                a = 16'($urandom);
                l = 5'($urandom_range(0, 31));
                for (int i = 0; i < 16; i++) wdat[i] = 16'($urandom);
                do_write(a, l, 16'($urandom) & 16'($urandom));
                do_read(a, 5'($urandom_range(0, 31)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
